// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the hazard scoreboard.
//   FWD_RF    - forward select meaning "take operand from register file"
//   LAT_ALU   - ready age of a plain ALU result (available at MEM output)
//   LAT_LOAD  - ready age of a load result (available in WB)
//   SB_AW     - storage width of age/rdy fields; covers WB_AGE up to 15
//   sb_entry_t- per-register scoreboard entry {valid, age, rdy}
//   clamp_lat - force a requested ready age into [LAT_ALU, max_age]
package hazard_pkg;
  localparam int FWD_RF   = 0;
  localparam int LAT_ALU  = 2;
  localparam int LAT_LOAD = 3;
  localparam int SB_AW    = 4;

  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:0] age;
    logic [SB_AW-1:0] rdy;
  } sb_entry_t;

  function automatic logic [SB_AW-1:0] clamp_lat(input logic [SB_AW-1:0] lat,
                                                 input logic [SB_AW-1:0] max_age);
    if (lat < SB_AW'(LAT_ALU)) return SB_AW'(LAT_ALU);
    if (lat > max_age)         return max_age;
    return lat;
  endfunction
endpackage

// File: rtl/sb_entry.sv
// sb_entry: scoreboard slot for one architectural register.
//   clk_i, rst_i - clock, async active-high reset
//   i_age_en     - pipe advancing this edge (not held)
//   i_wr         - a new writer of this register issues this edge
//   i_rdy        - clamped ready age of that writer
//   o_entry      - current {valid, age, rdy}
// A new writer always wins over aging, so the youngest producer is tracked.
module sb_entry
  import hazard_pkg::*;
#(
  parameter int WB_AGE = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_age_en,
  input  logic             i_wr,
  input  logic [SB_AW-1:0] i_rdy,
  output sb_entry_t        o_entry
);
  sb_entry_t r_ent;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ent <= '0;
    end else if (i_wr) begin
      r_ent <= '{valid: 1'b1, age: SB_AW'(1), rdy: i_rdy};
    end else if (i_age_en && r_ent.valid) begin
      // Producer leaving WB: the register file now holds the value.
      if (r_ent.age == SB_AW'(WB_AGE)) r_ent <= '0;
      else                             r_ent.age <= r_ent.age + SB_AW'(1);
    end
  end

  assign o_entry = r_ent;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW hazard detection and forwarding control for the
// in-order pipeline, built on a per-register age/ready-age scoreboard.
//   clk_i, rst_i  - clock, async active-high reset
//   id_valid_i    - ID holds a valid instruction
//   rs_i/rs_use_i - packed source addresses (src0 in LSBs) and use flags
//   rd_i/rd_wen_i - destination and write enable
//   lat_i         - ready age of the result (clamped to [2, WB_AGE])
//   hold_i        - whole back end frozen
//   flush_i       - kill ID instruction (redirect in EX)
//   stall_o       - hold PC/IF-ID, bubble into ID/EX
//   issue_o       - ID instruction moves to EX this edge
//   fwd_sel_ex_o  - per-source forward select for the EX instruction
//   stall_cnt_o   - saturating count of RAW stall cycles
//   lat_err_o     - sticky flag: out-of-range lat_i issued
// WB_AGE must stay below 16 (width of the stored age fields).
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter  int NREG   = 32,
  parameter  int RAW    = $clog2(NREG),
  parameter  int NSRC   = 2,
  parameter  int WB_AGE = 3,
  parameter  int CNTW   = 32,
  localparam int LW     = $clog2(WB_AGE + 1),
  localparam int FW     = $clog2(WB_AGE)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                id_valid_i,
  input  logic [NSRC*RAW-1:0] rs_i,
  input  logic [NSRC-1:0]     rs_use_i,
  input  logic [RAW-1:0]      rd_i,
  input  logic                rd_wen_i,
  input  logic [LW-1:0]       lat_i,
  input  logic                hold_i,
  input  logic                flush_i,
  output logic                stall_o,
  output logic                issue_o,
  output logic [NSRC*FW-1:0]  fwd_sel_ex_o,
  output logic [CNTW-1:0]     stall_cnt_o,
  output logic                lat_err_o
);
  localparam logic [SB_AW-1:0] WB = SB_AW'(WB_AGE);

  sb_entry_t                 w_sb [NREG];
  logic [NSRC-1:0]           w_hz;
  logic [NSRC-1:0][FW-1:0]   w_sel;
  logic                      w_raw;
  logic                      w_wr;
  logic [SB_AW-1:0]          w_lat;
  logic [SB_AW-1:0]          w_rdy;
  logic                      w_lat_bad;

  logic [NSRC-1:0][FW-1:0]   r_fwd;
  logic [CNTW-1:0]           r_cnt;
  logic                      r_lat_err;

  // x0 is hardwired zero and never has a producer.
  assign w_sb[0] = '0;

  for (genvar g = 1; g < NREG; g++) begin : g_ent
    sb_entry #(.WB_AGE(WB_AGE)) u_ent (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .i_age_en (~hold_i),
      .i_wr     (w_wr && (rd_i == RAW'(g))),
      .i_rdy    (w_rdy),
      .o_entry  (w_sb[g])
    );
  end

  // Consumer reaches EX when the producer is one age older than now.
  // Producer at WB_AGE is written this edge (write-first RF), so read RF.
  for (genvar k = 0; k < NSRC; k++) begin : g_src
    logic [RAW-1:0]   w_rs;
    sb_entry_t        w_e;
    logic [SB_AW-1:0] w_next;
    logic             w_trk;

    assign w_rs     = rs_i[k*RAW +: RAW];
    assign w_e      = w_sb[w_rs];
    assign w_next   = w_e.age + SB_AW'(1);
    assign w_trk    = rs_use_i[k] && (w_rs != '0) && w_e.valid && (w_e.age != WB);
    assign w_hz[k]  = w_trk && (w_next < w_e.rdy);
    assign w_sel[k] = (w_trk && !w_hz[k]) ? FW'(w_e.age) : FW'(FWD_RF);
  end

  assign w_raw   = id_valid_i & (|w_hz);
  // flush wins so IF can redirect even while the back end is frozen.
  assign stall_o = ~rst_i & ~flush_i & (hold_i | w_raw);
  assign issue_o = ~rst_i & id_valid_i & ~stall_o & ~flush_i & ~hold_i;

  assign w_wr      = issue_o & rd_wen_i & (rd_i != '0);
  assign w_lat     = SB_AW'(lat_i);
  assign w_rdy     = clamp_lat(w_lat, WB);
  assign w_lat_bad = (w_lat < SB_AW'(LAT_ALU)) | (w_lat > WB);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fwd     <= '0;
      r_cnt     <= '0;
      r_lat_err <= 1'b0;
    end else begin
      if (!hold_i) begin
        // Bubble into EX carries no forwarding.
        r_fwd <= issue_o ? w_sel : '0;
        if (w_raw && !flush_i && (r_cnt != '1)) r_cnt <= r_cnt + CNTW'(1);
      end
      if (issue_o && rd_wen_i && w_lat_bad) r_lat_err <= 1'b1;
    end
  end

  assign fwd_sel_ex_o = r_fwd;
  assign stall_cnt_o  = r_cnt;
  assign lat_err_o    = r_lat_err;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: WB_AGE=3 main instance plus a
// WB_AGE=5 instance sharing the same ID-stage stimulus.
module tb_hazard_scoreboard;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [9:0]  rs;
  logic [1:0]  rs_use;
  logic [4:0]  rd;
  logic        rd_wen;
  logic [1:0]  lat;
  logic [2:0]  lat5;
  logic        hold;
  logic        flush;

  logic        stall, issue, lerr;
  logic [3:0]  fwd;
  logic [31:0] cnt;
  logic        stall5, issue5, lerr5;
  logic [5:0]  fwd5;
  logic [31:0] cnt5;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .rs_i(rs), .rs_use_i(rs_use),
    .rd_i(rd), .rd_wen_i(rd_wen), .lat_i(lat), .hold_i(hold), .flush_i(flush),
    .stall_o(stall), .issue_o(issue), .fwd_sel_ex_o(fwd), .stall_cnt_o(cnt),
    .lat_err_o(lerr)
  );

  hazard_scoreboard #(.WB_AGE(5)) dut5 (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .rs_i(rs), .rs_use_i(rs_use),
    .rd_i(rd), .rd_wen_i(rd_wen), .lat_i(lat5), .hold_i(hold), .flush_i(flush),
    .stall_o(stall5), .issue_o(issue5), .fwd_sel_ex_o(fwd5), .stall_cnt_o(cnt5),
    .lat_err_o(lerr5)
  );

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic id(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                    input logic [1:0] u, input logic [4:0] d, input logic w, input int l);
    id_valid = v; rs = {s1, s0}; rs_use = u; rd = d; rd_wen = w;
    lat = l[1:0]; lat5 = l[2:0];
  endtask

  task automatic idle();
    id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2);
    hold = 1'b0; flush = 1'b0;
  endtask

  task automatic apply_reset();
    idle(); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; hold = 1'b1; flush = 1'b0;
    id(1'b1, 5'd3, 5'd4, 2'b11, 5'd6, 1'b1, 2);
    repeat (2) @(posedge clk); #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall); end
    checks++; if (issue !== 1'b0) begin failures++; $display("FAIL reset_issue got=%0b exp=0", issue); end
    checks++; if (fwd !== 4'h0) begin failures++; $display("FAIL reset_fwd got=%0h exp=0", fwd); end
    checks++; if (cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    checks++; if (lerr !== 1'b0) begin failures++; $display("FAIL reset_lerr got=%0b exp=0", lerr); end
    idle(); #1 rst = 1'b0; #1;
  endtask

  task automatic test_alu_fwd();
    apply_reset();
    id(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 2); #1;      // add x5
    checks++; if (issue !== 1'b1) begin failures++; $display("FAIL alu_prod_issue got=%0b exp=1", issue); end
    cyc();
    id(1'b1, 5'd5, 5'd0, 2'b01, 5'd9, 1'b1, 2); #1;      // add x9 <- x5
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL alu_adj_stall got=%0b exp=0", stall); end
    checks++; if (issue !== 1'b1) begin failures++; $display("FAIL alu_adj_issue got=%0b exp=1", issue); end
    cyc();
    checks++; if (fwd !== 4'h1) begin failures++; $display("FAIL alu_adj_fwd got=%0h exp=1", fwd); end
    id(1'b1, 5'd0, 5'd5, 2'b10, 5'd10, 1'b1, 2); #1;     // add x10 <- x5 (one gap, src1)
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL alu_gap1_stall got=%0b exp=0", stall); end
    cyc();
    checks++; if (fwd !== 4'h8) begin failures++; $display("FAIL alu_gap1_fwd got=%0h exp=8", fwd); end
    id(1'b1, 5'd5, 5'd10, 2'b11, 5'd11, 1'b1, 2); #1;    // x5 two gaps (RF), x10 adjacent
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL alu_gap2_stall got=%0b exp=0", stall); end
    cyc();
    checks++; if (fwd !== 4'h4) begin failures++; $display("FAIL alu_gap2_fwd got=%0h exp=4", fwd); end
    idle(); cyc();
    checks++; if (fwd !== 4'h0) begin failures++; $display("FAIL alu_bubble_fwd got=%0h exp=0", fwd); end
  endtask

  task automatic test_load_stall();
    apply_reset();
    id(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 3); cyc();   // lw x6
    id(1'b1, 5'd0, 5'd6, 2'b10, 5'd12, 1'b1, 2); #1;     // add rs2=x6
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL load_stall got=%0b exp=1", stall); end
    checks++; if (issue !== 1'b0) begin failures++; $display("FAIL load_stall_issue got=%0b exp=0", issue); end
    cyc();
    checks++; if (cnt !== 32'd1) begin failures++; $display("FAIL load_cnt got=%0d exp=1", cnt); end
    checks++; if (stall !== 1'b0 || issue !== 1'b1) begin failures++; $display("FAIL load_release got=%0b/%0b exp=0/1", stall, issue); end
    cyc();
    checks++; if (fwd !== 4'h8) begin failures++; $display("FAIL load_fwd got=%0h exp=8", fwd); end
    idle();
  endtask

  task automatic test_wb5();
    apply_reset();
    id(1'b1, 5'd0, 5'd0, 2'b00, 5'd13, 1'b1, 5); #1;     // lat 5 producer
    checks++; if (issue5 !== 1'b1) begin failures++; $display("FAIL wb5_prod_issue got=%0b exp=1", issue5); end
    cyc();
    id(1'b1, 5'd13, 5'd0, 2'b01, 5'd14, 1'b1, 2);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stall5 !== 1'b1) begin failures++; $display("FAIL wb5_stall%0d got=%0b exp=1", i, stall5); end
      cyc();
    end
    checks++; if (stall5 !== 1'b0 || issue5 !== 1'b1) begin failures++; $display("FAIL wb5_release got=%0b/%0b exp=0/1", stall5, issue5); end
    cyc();
    checks++; if (fwd5 !== 6'd4) begin failures++; $display("FAIL wb5_fwd got=%0d exp=4", fwd5); end
    checks++; if (cnt5 !== 32'd3) begin failures++; $display("FAIL wb5_cnt got=%0d exp=3", cnt5); end
    id(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 5); cyc();   // producer to x0
    id(1'b1, 5'd0, 5'd0, 2'b01, 5'd15, 1'b1, 2); #1;
    checks++; if (stall5 !== 1'b0 || issue5 !== 1'b1) begin failures++; $display("FAIL wb5_x0 got=%0b/%0b exp=0/1", stall5, issue5); end
    idle();
  endtask

  task automatic test_flush();
    apply_reset();
    id(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 2); cyc();   // add x5
    id(1'b1, 5'd5, 5'd0, 2'b01, 5'd6, 1'b1, 3); cyc();   // lw x6 <- x5, fwd=1
    id(1'b1, 5'd6, 5'd0, 2'b01, 5'd12, 1'b1, 2); flush = 1'b1; #1;
    checks++; if (stall !== 1'b0 || issue !== 1'b0) begin failures++; $display("FAIL flush_ctl got=%0b/%0b exp=0/0", stall, issue); end
    cyc();
    checks++; if (fwd !== 4'h0) begin failures++; $display("FAIL flush_fwd got=%0h exp=0", fwd); end
    checks++; if (cnt !== 32'd0) begin failures++; $display("FAIL flush_cnt got=%0d exp=0", cnt); end
    flush = 1'b0; #1;                                     // x6 now age 2: no stall
    checks++; if (stall !== 1'b0 || issue !== 1'b1) begin failures++; $display("FAIL flush_age got=%0b/%0b exp=0/1", stall, issue); end
    cyc();
    checks++; if (fwd !== 4'h2) begin failures++; $display("FAIL flush_after_fwd got=%0h exp=2", fwd); end
    idle();
  endtask

  task automatic test_hold();
    apply_reset();
    id(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 2); cyc();
    id(1'b1, 5'd5, 5'd0, 2'b01, 5'd6, 1'b1, 3); cyc();   // lw x6 <- x5
    checks++; if (fwd !== 4'h1) begin failures++; $display("FAIL hold_pre_fwd got=%0h exp=1", fwd); end
    id(1'b1, 5'd0, 5'd6, 2'b10, 5'd12, 1'b1, 2); hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (stall !== 1'b1 || issue !== 1'b0) begin failures++; $display("FAIL hold_ctl%0d got=%0b/%0b exp=1/0", i, stall, issue); end
      cyc();
    end
    checks++; if (fwd !== 4'h1) begin failures++; $display("FAIL hold_fwd got=%0h exp=1", fwd); end
    checks++; if (cnt !== 32'd0) begin failures++; $display("FAIL hold_cnt got=%0d exp=0", cnt); end
    hold = 1'b0; #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL hold_rem_stall got=%0b exp=1", stall); end
    cyc();
    checks++; if (cnt !== 32'd1 || fwd !== 4'h0) begin failures++; $display("FAIL hold_rem got=%0d/%0h exp=1/0", cnt, fwd); end
    checks++; if (issue !== 1'b1) begin failures++; $display("FAIL hold_issue got=%0b exp=1", issue); end
    cyc();
    checks++; if (fwd !== 4'h8) begin failures++; $display("FAIL hold_final_fwd got=%0h exp=8", fwd); end
    idle();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    id(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 3); cyc();   // lw x7
    id(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 2); #1;      // add x7
    checks++; if (issue !== 1'b1) begin failures++; $display("FAIL b2b_w2_issue got=%0b exp=1", issue); end
    cyc();
    id(1'b1, 5'd7, 5'd0, 2'b01, 5'd16, 1'b1, 2); #1;
    checks++; if (stall !== 1'b0 || issue !== 1'b1) begin failures++; $display("FAIL b2b_cons got=%0b/%0b exp=0/1", stall, issue); end
    cyc();
    checks++; if (fwd !== 4'h1) begin failures++; $display("FAIL b2b_fwd got=%0h exp=1", fwd); end
    idle();
  endtask

  task automatic test_mid_reset();
    apply_reset();
    id(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 3); cyc();
    id(1'b1, 5'd6, 5'd0, 2'b01, 5'd12, 1'b1, 2); #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL mid_pre_stall got=%0b exp=1", stall); end
    cyc();
    checks++; if (cnt !== 32'd1) begin failures++; $display("FAIL mid_pre_cnt got=%0d exp=1", cnt); end
    #1 rst = 1'b1; #1;
    checks++; if (cnt !== 32'd0 || stall !== 1'b0 || issue !== 1'b0) begin failures++; $display("FAIL mid_rst got=%0d/%0b/%0b exp=0/0/0", cnt, stall, issue); end
    #1 rst = 1'b0; #1;
    checks++; if (stall !== 1'b0 || issue !== 1'b1) begin failures++; $display("FAIL mid_post got=%0b/%0b exp=0/1", stall, issue); end
    cyc();
    checks++; if (fwd !== 4'h0) begin failures++; $display("FAIL mid_post_fwd got=%0h exp=0", fwd); end
    idle();
  endtask

  task automatic test_lat_err();
    apply_reset();
    checks++; if (lerr !== 1'b0) begin failures++; $display("FAIL laterr_init got=%0b exp=0", lerr); end
    id(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1); cyc();   // lat 1 -> clamped to 2
    checks++; if (lerr !== 1'b1) begin failures++; $display("FAIL laterr_set got=%0b exp=1", lerr); end
    id(1'b1, 5'd5, 5'd0, 2'b01, 5'd8, 1'b1, 2); #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL laterr_clamp_stall got=%0b exp=0", stall); end
    cyc();
    checks++; if (fwd !== 4'h1) begin failures++; $display("FAIL laterr_clamp_fwd got=%0h exp=1", fwd); end
    idle(); cyc(); cyc();
    checks++; if (lerr !== 1'b1) begin failures++; $display("FAIL laterr_sticky got=%0b exp=1", lerr); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    test_reset();
    test_alu_fwd();
    test_load_stall();
    test_wb5();
    test_flush();
    test_hold();
    test_back_to_back();
    test_mid_reset();
    test_lat_err();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
